// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single 32x32 synchronous RAM.
// A CPU and a host (loader/debug) port share the RAM with round-robin
// priority. Every access takes three cycles: IDLE (arbitrate),
// ACCESS (address/strobe on the RAM), WAIT (RAM read data arrives).
module ram_arbiter (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        c_req_i,
  input  logic        c_we_i,
  input  logic [4:0]  c_addr_i,
  input  logic [31:0] c_wdata_i,
  output logic        c_gnt_o,
  output logic        c_done_o,
  output logic [31:0] c_rdata_o,
  input  logic        h_req_i,
  input  logic        h_we_i,
  input  logic [4:0]  h_addr_i,
  input  logic [31:0] h_wdata_i,
  output logic        h_gnt_o,
  output logic        h_done_o,
  output logic [31:0] h_rdata_o,
  output logic        c_stall_o,
  output logic [4:0]  ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic        ram_rw_en_o,
  input  logic [31:0] ram_data_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        rw_en_q, rw_en_d;
  logic        c_gnt_q, c_gnt_d;
  logic        h_gnt_q, h_gnt_d;
  logic        c_done_q, c_done_d;
  logic        h_done_q, h_done_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] h_rdata_q, h_rdata_d;
  // last_host_q: 1 when the host won the most recent grant
  logic        last_host_q, last_host_d;
  // owner_host_q / op_we_q: who owns the access in flight and whether it writes
  logic        owner_host_q, owner_host_d;
  logic        op_we_q, op_we_d;
  logic        grant_host;

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      rw_en_q      <= 1'b0;
      c_gnt_q      <= 1'b0;
      h_gnt_q      <= 1'b0;
      c_done_q     <= 1'b0;
      h_done_q     <= 1'b0;
      c_rdata_q    <= '0;
      h_rdata_q    <= '0;
      last_host_q  <= 1'b1;
      owner_host_q <= 1'b0;
      op_we_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rw_en_q      <= rw_en_d;
      c_gnt_q      <= c_gnt_d;
      h_gnt_q      <= h_gnt_d;
      c_done_q     <= c_done_d;
      h_done_q     <= h_done_d;
      c_rdata_q    <= c_rdata_d;
      h_rdata_q    <= h_rdata_d;
      last_host_q  <= last_host_d;
      owner_host_q <= owner_host_d;
      op_we_q      <= op_we_d;
    end
  end

  // Arbitration, access sequencing and read-data capture
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rw_en_d      = 1'b0;
    c_gnt_d      = 1'b0;
    h_gnt_d      = 1'b0;
    c_done_d     = 1'b0;
    h_done_d     = 1'b0;
    c_rdata_d    = c_rdata_q;
    h_rdata_d    = h_rdata_q;
    last_host_d  = last_host_q;
    owner_host_d = owner_host_q;
    op_we_d      = op_we_q;
    grant_host   = 1'b0;
    case (state_q)
      IDLE: begin
        if (c_req_i || h_req_i) begin
          // On a tie the side that lost last time wins
          grant_host = h_req_i && (!c_req_i || !last_host_q);
          if (grant_host) begin
            addr_d  = h_addr_i;
            data_d  = h_wdata_i;
            rw_en_d = h_we_i;
            op_we_d = h_we_i;
            h_gnt_d = 1'b1;
          end else begin
            addr_d  = c_addr_i;
            data_d  = c_wdata_i;
            rw_en_d = c_we_i;
            op_we_d = c_we_i;
            c_gnt_d = 1'b1;
          end
          owner_host_d = grant_host;
          last_host_d  = grant_host;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d = IDLE;
        if (owner_host_q) begin
          h_done_d = 1'b1;
          if (!op_we_q) begin
            h_rdata_d = ram_data_i;
          end
        end else begin
          c_done_d = 1'b1;
          if (!op_we_q) begin
            c_rdata_d = ram_data_i;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign c_gnt_o     = c_gnt_q;
  assign h_gnt_o     = h_gnt_q;
  assign c_done_o    = c_done_q;
  assign h_done_o    = h_done_q;
  assign c_rdata_o   = c_rdata_q;
  assign h_rdata_o   = h_rdata_q;
  assign ram_addr_o  = addr_q;
  assign ram_data_o  = data_q;
  assign ram_rw_en_o = rw_en_q;
  assign c_stall_o   = c_req_i && !c_gnt_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i is the single clock, and reset_n_i is the asynchronous, active-low reset.
REQ-002 The block SHALL have no parameters: address width is fixed at 5 bits and data width at 32 bits, matching the 32-word store.
REQ-003 The block SHALL provide these ports, in this order (name, direction, width, meaning):
- clk_i  in  1  rising-edge clock
- reset_n_i  in  1  asynchronous reset, active low
- c_req_i  in  1  CPU access request
- c_we_i  in  1  CPU write (1) or read (0)
- c_addr_i  in  5  CPU word address
- c_wdata_i  in  32  CPU write data
- c_gnt_o  out  1  CPU grant pulse
- c_done_o  out  1  CPU completion pulse
- c_rdata_o  out  32  CPU read data
- h_req_i / h_we_i / h_addr_i / h_wdata_i  in  1/1/5/32  host (loader/debug) request fields, same meaning as the CPU fields
- h_gnt_o / h_done_o / h_rdata_o  out  1/1/32  host grant, completion pulse and read data
- c_stall_o  out  1  high when c_req_i is high and c_gnt_o is low
- ram_addr_o  out  5  RAM address
- ram_data_o  out  32  RAM write data
- ram_rw_en_o  out  1  RAM write enable, 1 = write
- ram_data_i  in  32  RAM read data, valid one cycle after the address is presented

Function
REQ-004 The block SHALL implement a three-state FSM: IDLE, ACCESS, WAIT.
REQ-005 In IDLE with at least one request high, the block SHALL select a winner at the clock edge and then:
- register the winner's addr, we and wdata onto ram_addr_o, ram_rw_en_o and ram_data_o;
- pulse the winner's gnt high for exactly one cycle;
- move to ACCESS.
REQ-006 Arbitration SHALL be round-robin:
- a single requester always wins;
- when both request, the requester that did not win the previous grant wins;
- last_grant resets to host, so the CPU wins the first tie.
REQ-007 From ACCESS, the block SHALL go to WAIT on the next edge unconditionally, and ram_rw_en_o SHALL return to 0 on that edge, so a write strobe is exactly one cycle wide.
REQ-008 From WAIT, the block SHALL go to IDLE on the next edge. On that edge:
- for a read, the winner's rdata SHALL capture ram_data_i;
- for reads and writes alike, the winner's done SHALL pulse high for one cycle.
REQ-009 Latency SHALL be fixed: gnt is high 1 cycle after request sampling, and done is high 3 cycles after sampling. Maximum throughput is one access per 3 cycles.
REQ-010 rdata outputs SHALL hold their last captured value until the next read by the same requester.
REQ-011 Writes SHALL NOT alter rdata.
REQ-012 Requests, and requests dropped before grant:
- each requester SHALL hold req and its fields stable until its gnt pulse;
- a request still high in IDLE after done SHALL be treated as a new access;
- a request deasserted before gnt SHALL cause no RAM activity and no gnt pulse.
REQ-013 Request inputs SHALL be ignored in ACCESS and WAIT; a request arriving then is arbitrated in the next IDLE cycle.
REQ-014 While idle, ram_addr_o and ram_data_o SHALL hold their last values, and ram_rw_en_o SHALL be 0.
REQ-015 c_stall_o SHALL be combinational.
REQ-016 gnt and done SHALL never be high for both requesters in the same cycle.

Reset
REQ-017 Asserting reset_n_i low SHALL immediately force all of the following, including mid-access:
- state = IDLE;
- ram_rw_en_o = 0;
- ram_addr_o = 0 and ram_data_o = 0;
- all gnt and done outputs = 0;
- both rdata outputs = 0;
- last_grant = host.
REQ-018 An access interrupted by reset SHALL produce no done pulse.
REQ-019 The first arbitration SHALL occur on the first rising edge after reset_n_i goes high.

Verification
REQ-020 CPU write then read: c_req_i high with we=1, addr=5, wdata=0xDEADBEEF, then a read of addr 5. Required response:
- ram_rw_en_o high for exactly 1 cycle;
- the read's c_done_o arrives 3 cycles after sampling;
- c_rdata_o = 0xDEADBEEF.
REQ-021 Simultaneous requests held for three accesses after reset. Required response: grant order CPU, host, CPU, and c_stall_o is high during each host access.
REQ-022 Host-only request stream, 4 reads of addresses 0 to 3. Required response:
- h_gnt_o pulses every 3 cycles;
- h_rdata_o matches RAM contents;
- c_rdata_o is unchanged.
REQ-023 Reset asserted during ACCESS of a write. Required response:
- ram_rw_en_o drops to 0 asynchronously;
- no h_done_o or c_done_o pulse follows;
- all outputs are 0.
REQ-024 Request raised during WAIT. Required response: no grant until IDLE; the grant follows on the IDLE edge.
REQ-025 A request pulsed for 0 cycles of IDLE (low again before the sampling edge). Required response: no gnt pulse, and ram_rw_en_o stays 0.
